// File: rtl/proc_control_fsm_pkg.sv
// proc_pkg: opcodes, ALU selects, timestep encoding and IR field positions shared by the control unit.
package proc_pkg;
  localparam logic [3:0] OP_MV = 4'h0;
  localparam logic [3:0] OP_MVI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_AND = 4'h4;
  localparam logic [3:0] OP_SLT = 4'h5;
  localparam logic [3:0] OP_SLL = 4'h6;
  localparam logic [3:0] OP_SRL = 4'h7;
  localparam logic [3:0] OP_MVNZ = 4'h8;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int X_HI = 11;
  localparam int X_LO = 9;
  localparam int Y_HI = 8;
  localparam int Y_LO = 6;
  typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} state_e;
  function automatic logic is_alu(input logic [3:0] op);
    return op >= OP_ADD && op <= OP_SRL;
  endfunction
  // ALU opcodes are contiguous from add, so the select is just the offset from OP_ADD.
  function automatic logic [2:0] alu_of(input logic [3:0] op);
    return op[2:0] - OP_ADD[2:0];
  endfunction
endpackage

// File: rtl/proc_control_fsm_if.sv
// proc_control_fsm_if: instruction input and datapath control strobes of the control unit.
interface proc_control_fsm_if #(parameter int n = 16, parameter int NREG = 8);
  logic Run;
  logic [n-1:0] DIN;
  logic G_nonzero;
  logic IRin;
  logic [NREG-1:0] Rin;
  logic [NREG-1:0] Rout;
  logic Gout;
  logic DINout;
  logic Ain;
  logic Gin;
  logic [2:0] alu_control;
  logic Done;
  logic Busy;
  modport master(output Run, DIN, G_nonzero,
                 input IRin, Rin, Rout, Gout, DINout, Ain, Gin, alu_control, Done, Busy);
  modport slave(input Run, DIN, G_nonzero,
                output IRin, Rin, Rout, Gout, DINout, Ain, Gin, alu_control, Done, Busy);
endinterface

// File: rtl/proc_control_fsm_dec3to8.sv
// dec3to8: 3-bit to one-hot 8 decoder with enable.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);
  assign onehot_o = en_i ? 8'b1 << sel_i : 8'b0;
endmodule

// File: rtl/proc_control_fsm.sv
// proc_control_fsm: multicycle T0-T3 control unit; captures an instruction and sequences the datapath strobes.
module proc_control_fsm
  import proc_pkg::*;
#(
  parameter int n = 16,
  parameter int NREG = 8
) (
  input logic Clock,
  input logic Reset,
  proc_control_fsm_if.slave bus
);
  state_e state_q, state_d;
  logic [n-1:0] ir_q, ir_d;
  logic [3:0] op;
  logic [NREG-1:0] x_oh, y_oh;
  logic irin, rin_x, rout_x, rout_y;
  logic unused_ir;
  assign op = ir_q[OP_HI:OP_LO];
  assign unused_ir = ^ir_q[Y_LO-1:0];
  dec3to8 u_dec_x (.en_i(1'b1), .sel_i(ir_q[X_HI:X_LO]), .onehot_o(x_oh));
  dec3to8 u_dec_y (.en_i(1'b1), .sel_i(ir_q[Y_HI:Y_LO]), .onehot_o(y_oh));
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= T0;
      ir_q <= '0;
    end else begin
      state_q <= state_d;
      ir_q <= ir_d;
    end
  end
  always_comb begin
    state_d = state_q;
    ir_d = ir_q;
    irin = 1'b0;
    rin_x = 1'b0;
    rout_x = 1'b0;
    rout_y = 1'b0;
    bus.Gout = 1'b0;
    bus.DINout = 1'b0;
    bus.Ain = 1'b0;
    bus.Gin = 1'b0;
    bus.alu_control = ALU_ADD;
    bus.Done = 1'b0;
    case (state_q)
      T0: begin
        irin = bus.Run;
        ir_d = bus.Run ? bus.DIN : ir_q;
        state_d = bus.Run ? T1 : T0;
      end
      T1: begin
        rout_x = is_alu(op);
        bus.Ain = is_alu(op);
        bus.Done = !is_alu(op);
        state_d = is_alu(op) ? T2 : T0;
        rout_y = op == OP_MV || (op == OP_MVNZ && bus.G_nonzero);
        bus.DINout = op == OP_MVI;
        rin_x = op == OP_MV || op == OP_MVI || (op == OP_MVNZ && bus.G_nonzero);
      end
      T2: begin
        rout_y = 1'b1;
        bus.Gin = 1'b1;
        bus.alu_control = alu_of(op);
        state_d = T3;
      end
      default: begin
        bus.Gout = 1'b1;
        rin_x = 1'b1;
        bus.Done = 1'b1;
        state_d = T0;
      end
    endcase
  end
  assign bus.IRin = irin && !Reset;
  assign bus.Rin = rin_x ? x_oh : '0;
  assign bus.Rout = rout_x ? x_oh : rout_y ? y_oh : '0;
  assign bus.Busy = state_q != T0;
endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Multicycle control unit for the 16-bit simple processor.
- Captures each instruction word from DIN and sequences it over timesteps T0-T3.
- Drives the register-file load/output enables, the bus-source selects, and the Ain/Gin strobes.
- Drives the 3-bit alu_control consumed directly by the ALU stage, and signals Done at the end of every instruction.

Parameters:
- n, 16, data/instruction word width (DIN and internal IR).
- NREG, 8, number of general registers; register fields are 3 bits and NREG must be 8.

Ports:
- Clock  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Run  in  1  start request, sampled only in T0.
- DIN  in  n  instruction/immediate word.
- G_nonzero  in  1  G register is non-zero; used by mvnz.
- IRin  out  1  IR capture strobe, observable.
- Rin  out  NREG  one-hot register load enables.
- Rout  out  NREG  one-hot register-to-bus enables.
- Gout  out  1  G register drives the bus.
- DINout  out  1  DIN drives the bus.
- Ain  out  1  load A register.
- Gin  out  1  load G register from the ALU.
- alu_control  out  3  ALU operation select.
- Done  out  1  instruction completes this cycle.
- Busy  out  1  high in T1..T3.

Behaviour:
- **IR format** (IR[n-1:0]):
  - IR[15:12] = opcode.
  - IR[11:9] = X, the destination register.
  - IR[8:6] = Y, the source register.
  - IR[5:0] unused.
- **Opcodes:**
  - 0000 mv
  - 0001 mvi
  - 0010 add
  - 0011 sub
  - 0100 and
  - 0101 slt
  - 0110 sll
  - 0111 srl
  - 1000 mvnz
  - 1001-1111 illegal
- **alu_control encoding:** add 000, sub 001, and 010, slt 011, sll 100, srl 101.
  - alu_control is 000 in every cycle except ALU-op T2.
- **State register:** 2-bit, states T0, T1, T2, T3. IR is an internal register.
- **Outputs:** all are combinational from state plus IR; all are 0 unless listed below.
- **T0:**
  - IRin = Run.
  - If Run=1: IR <= DIN, next state T1.
  - If Run=0: stay in T0, IR holds.
- **T1:**
  - mv: Rout[Y]=1, Rin[X]=1, Done=1, next T0.
  - mvi: DINout=1, Rin[X]=1, Done=1, next T0. The immediate is the DIN value present during T1.
  - mvnz: Done=1, next T0. If G_nonzero=1, also Rout[Y]=1 and Rin[X]=1.
  - ALU ops: Rout[X]=1, Ain=1, next T2.
  - illegal: Done=1, no other strobes, next T0.
- **T2 (ALU ops only):** Rout[Y]=1, Gin=1, alu_control=op code, next T3.
- **T3 (ALU ops only):** Gout=1, Rin[X]=1, Done=1, next T0.
- **Latency:**
  - mv / mvi / mvnz / illegal: 2 cycles from Run accepted in T0 to Done.
  - ALU ops: 4 cycles from Run accepted in T0 to Done.
  - Back-to-back: T3/T1 Done is followed by T0, so a held Run issues the next instruction with one T0 gap.
- **Run outside T0** is ignored; DIN changes outside T0 (except mvi T1) have no effect.
- **X == Y** is legal. mv R,R is a no-op write. add R,R drives Rout[X] in T1 and Rout[Y] in T2 as normal.
- **Bus exclusivity:** at most one of {Rout bits, Gout, DINout} is high in any cycle. This is an invariant.
- **Busy** = (state != T0).
- **Reset:**
  - Reset=1 at a rising edge sets state <= T0 and IR <= 0, overriding Run.
  - While Reset is high, all outputs are 0 in the following cycles, including IRin (IRin is gated by !Reset).
  - Reset mid-instruction (T1-T3) aborts the instruction; no Done is issued for it.

Decomposition:
- **Shared package (proc_pkg):**
  - opcode constants: OP_MV, OP_MVI, OP_ADD, OP_SUB, OP_AND, OP_SLT, OP_SLL, OP_SRL, OP_MVNZ.
  - ALU control constants: ALU_ADD=000 through ALU_SRL=101.
  - state encoding: T0=00, T1=01, T2=10, T3=11.
  - IR field positions.
- **Sub-module dec3to8:** 3-bit to one-hot 8 decoder with enable, instantiated twice for the X and Y fields.

Test Plan:
- **mvi:** Reset 1 cycle, Run=1, DIN=0x1200 (mvi R1) → T0 IRin=1; next cycle DINout=1, Rin=0x02, Done=1; next cycle all strobes 0.
- **add:** add R2,R3, DIN=0x24C0 → T1 Rout=0x04, Ain=1; T2 Rout=0x08, Gin=1, alu_control=000; T3 Gout=1, Rin=0x04, Done=1; Done exactly 3 cycles after IR capture.
- **ALU encodings:** sweep sub/and/slt/sll/srl (op 0011-0111) → alu_control = 001, 010, 011, 100, 101 in T2 only, and 000 in every other cycle. Check the bus-exclusivity assertion throughout.
- **mvnz:** mvnz R4,R5 (0x8940) with G_nonzero=0 → T1 Done=1, Rin=0, Rout=0. Repeat with G_nonzero=1 → Rout=0x20, Rin=0x10.
- **Illegal op and stray Run:** opcode 1111 → T1 Done=1 only. Run pulsed during T2 of an add → ignored; IR unchanged; add still completes.
- **Reset mid-op:** assert Reset in T2 of sub R0,R1 → next cycle state T0, all outputs 0, no Done. A subsequent mv R6,R7 (0x0DC0) executes normally.
